// File: rtl/mips_trace_capture_if.sv
// Beat stream from the trace FIFO to a host or checker.
// Master drives valid/data/last, slave returns ready.
interface mips_trace_capture_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/mips_trace_capture.sv
// Commit-trace monitor for the single-cycle mips core.
// Arms, triggers on a PC, buffers samples and streams 3 beats/entry.
module mips_trace_capture #(
    parameter int DEPTH       = 16,
    parameter bit CAPTURE_ALL = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [31:0]                 pc,
    input  logic [31:0]                 instr,
    input  logic [31:0]                 alu_result,
    input  logic                        reg_write,
    input  logic                        arm,
    input  logic                        clear,
    input  logic [31:0]                 trig_pc,
    input  logic [15:0]                 capture_len,
    mips_trace_capture_if.master        trace,
    output logic [1:0]                  state,
    output logic [15:0]                 captured,
    output logic [15:0]                 dropped,
    output logic                        done
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t      st;
    state_t      st_nxt;
    logic [95:0] mem [DEPTH];
    logic [95:0] head;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [1:0]  beat;
    logic        q;
    logic        trig;
    logic        push_req;
    logic        push_ok;
    logic        pop;
    logic        empty;
    logic        full;
    logic        hit_len;
    logic        rearm;
    logic [15:0] cap_inc;

    assign q        = CAPTURE_ALL || reg_write;
    assign trig     = (st == ARMED) && q && (pc == trig_pc);
    assign push_req = !clear && (trig || ((st == CAPTURE) && q));
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = !empty && trace.out_ready && (beat == 2'd2);
    // A final-beat pop in the same cycle frees the slot being written.
    assign push_ok  = push_req && (!full || pop);
    assign cap_inc  = captured + 16'd1;
    assign hit_len  = push_ok && (capture_len != 16'd0) &&
                      (cap_inc == capture_len);
    assign rearm    = arm && ((st == IDLE) || (st == DONE));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) st <= IDLE;
        else        st <= st_nxt;
    end

    // Next-state: clear wins, arm only honoured in IDLE/DONE.
    always_comb begin
        st_nxt = st;
        if (clear) begin
            st_nxt = IDLE;
        end else begin
            unique case (st)
                IDLE:    if (arm) st_nxt = ARMED;
                ARMED:   if (trig) st_nxt = hit_len ? DONE : CAPTURE;
                CAPTURE: if (hit_len) st_nxt = DONE;
                DONE:    if (arm) st_nxt = ARMED;
                default: st_nxt = IDLE;
            endcase
        end
    end

    // Run counters; dropped saturates.
    always_ff @(posedge clk) begin
        if (!rst_n || clear || (!clear && rearm)) begin
            captured <= 16'd0;
            dropped  <= 16'd0;
        end else begin
            if (push_ok) captured <= cap_inc;
            if (push_req && !push_ok && (dropped != 16'hFFFF))
                dropped <= dropped + 16'd1;
        end
    end

    // Sample storage, no reset needed: reads are gated by occupancy.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= {pc, instr, alu_result};
    end

    // Pointers with an extra wrap bit to tell full from empty.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Beat index within the head entry.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            beat <= 2'd0;
        end else if (!empty && trace.out_ready) begin
            beat <= (beat == 2'd2) ? 2'd0 : beat + 2'd1;
        end
    end

    assign head = mem[rd_ptr[AW-1:0]];

    // Beat mux: pc, instr, alu_result; zero when nothing queued.
    always_comb begin
        trace.out_data = 32'd0;
        if (!empty) begin
            unique case (beat)
                2'd0:    trace.out_data = head[95:64];
                2'd1:    trace.out_data = head[63:32];
                2'd2:    trace.out_data = head[31:0];
                default: trace.out_data = 32'd0;
            endcase
        end
    end

    assign trace.out_valid = !empty;
    assign trace.out_last  = !empty && (beat == 2'd2);
    assign state           = st;
    assign done            = (st == DONE);
endmodule
